alu_sweep_driver: RTL and testbench
===================================

# alu_sweep_driver

Host-side initiator for the 4-bit operand / 3-bit opcode registered ALU on the tiny-tile user interface. On a start handshake it latches two 4-bit operands and sweeps opcodes 0..5 across the ALU interface. It waits out the ALU's registered latency for each opcode, captures each 8-bit result into a 6-entry buffer, then streams the results out over a valid/ready port. It sits between the bench/host controller and the ALU, replacing manual pin driving.

## Interface
- ALU_LATENCY, 1, clock edges from an opcode change at the ALU pins to the result being valid at `alu_result`; legal range 1..4
- NUM_OPS, 6, opcodes swept (0..NUM_OPS-1); fixed at 6 for this ALU
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start_valid  in  1  host requests a sweep
- start_ready  out  1  high only in IDLE
- start_a  in  4  operand A, sampled on start handshake
- start_b  in  4  operand B, sampled on start handshake
- alu_a  out  4  operand A to the ALU (ALU zero-extends internally)
- alu_b  out  4  operand B to the ALU
- alu_op  out  3  opcode to the ALU
- alu_result  in  8  registered ALU result
- res_valid  out  1  result entry available
- res_ready  in  1  consumer accepts the entry
- res_data  out  8  captured result
- res_op  out  3  opcode that produced `res_data`
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the last result transfers

## Operation
- States: IDLE, ISSUE, WAIT, CAPTURE, DRAIN.
- IDLE:
  - start_ready=1; `alu_op`=3'b111 (ALU default, result 0); `alu_a`/`alu_b` hold their last values.
  - On start_valid&&start_ready: latch start_a/start_b into the `alu_a`/`alu_b` registers, set op index k=0, go to ISSUE.
- ISSUE (1 cycle): `alu_op`=k is already registered. Go to WAIT with wait counter = ALU_LATENCY-1; if ALU_LATENCY=1, go directly to CAPTURE.
- WAIT: decrement the counter; go to CAPTURE at 0.
- CAPTURE (1 cycle):
  - Write buf[k] <= alu_result.
  - If k<5: k<=k+1, drive `alu_op`<=k+1, go to ISSUE.
  - Else go to DRAIN with read index r=0 and drive `alu_op`<=3'b111.
- DRAIN:
  - res_valid=1, res_data=buf[r], res_op=r.
  - On res_valid&&res_ready: if r<5, r<=r+1; else go to IDLE and pulse done.
- Backpressure: while res_valid&&!res_ready, res_data and res_op hold stable indefinitely.
- Results are captured raw with no interpretation. Subtract wrap-around (e.g. 0xFE) and divide-by-zero values pass through unchanged.
- start_valid outside IDLE is ignored; no queuing; operands are not re-sampled.
- `alu_op` is always driven from a register, never combinationally.

## Timing
- Reset values, asynchronous on rst=1:
  - state=IDLE; k=0; r=0; buffer all 0x00.
  - alu_a=0, alu_b=0, alu_op=3'b111.
  - res_valid=0, res_data=0, res_op=0, busy=0, done=0, start_ready=1 (once rst deasserts).
- Reset mid-sweep or mid-drain: immediate return to IDLE; a partially drained sequence is lost and `done` does not pulse.
- Each opcode occupies ALU_LATENCY+1 cycles (ISSUE + WAIT + CAPTURE collapsed as specified). A full sweep takes 6*(ALU_LATENCY+1) cycles from the start-handshake edge to DRAIN entry.
- res_valid asserts the cycle after the final CAPTURE. With res_ready tied high, 6 transfers take 6 consecutive cycles.
- done is high exactly one cycle, the cycle after the sixth transfer edge, coincident with start_ready=1. A new start can be accepted in that same cycle.
- busy rises the cycle after the start handshake and falls with the return to IDLE.

## Test plan
- Basic sweep, bench ALU model with 1-cycle registered latency, a=9, b=3, res_ready=1 -> res_data 12,6,27,3,1,11 with res_op 0..5, then done pulses once; sweep takes 12 cycles.
- Wrap and divide-by-zero, a=3, b=5 then a=7, b=0, model divide-by-zero returns 0xFF -> sub result 0xFE; div result 0xFF; both captured unmodified.
- Latency parameter, ALU_LATENCY=3 with a 3-stage model, a=15, b=15 -> results 30,0,225,1,15,15; sweep takes 24 cycles.
- Backpressure, res_ready toggling 1,0,0,1,... -> no entry dropped or duplicated; res_data/res_op stable whenever stalled; start_valid pulsed during DRAIN is ignored.
- Reset mid-operation, rst asserted during WAIT of op 2 -> next edge shows IDLE, alu_op=3'b111, res_valid=0, done never pulses; a fresh sweep with a=1, b=1 gives 2,0,1,1,1,1.
- Back-to-back, start_valid held high -> second start accepted in the done cycle; second sweep results correct.

Source files
------------

// File: rtl/alu_sweep_driver_if.sv
// Start request, ALU pin and result stream signals of alu_sweep_driver.
// The master modport is the driver; the slave modport is the host/ALU side.
interface alu_sweep_driver_if;
    logic       start_valid;
    logic       start_ready;
    logic [3:0] start_a;
    logic [3:0] start_b;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_result;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [2:0] res_op;

    modport master (
        input  start_valid, start_a, start_b, alu_result, res_ready,
        output start_ready, alu_a, alu_b, alu_op, res_valid, res_data, res_op
    );

    modport slave (
        output start_valid, start_a, start_b, alu_result, res_ready,
        input  start_ready, alu_a, alu_b, alu_op, res_valid, res_data, res_op
    );
endinterface

// File: rtl/alu_sweep_driver.sv
// Sweeps opcodes 0..NUM_OPS-1 over a registered ALU for one latched operand pair,
// buffers every result, then streams the buffer out over a valid/ready port.
module alu_sweep_driver #(
    parameter int ALU_LATENCY = 1,
    parameter int NUM_OPS     = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    alu_sweep_driver_if.master        bus,
    output logic                      busy,
    output logic                      done
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CAPTURE,
        DRAIN
    } state_t;

    localparam logic [2:0] OP_IDLE   = 3'b111;
    localparam logic [2:0] LAST_OP   = 3'(NUM_OPS - 1);
    localparam logic [1:0] WAIT_INIT = 2'(ALU_LATENCY - 1);

    state_t     state_q, state_d;
    logic [2:0] k_q, k_d;
    logic [2:0] r_q, r_d;
    logic [2:0] r_next;
    logic [1:0] wait_q, wait_d;
    logic [3:0] alu_a_q, alu_a_d;
    logic [3:0] alu_b_q, alu_b_d;
    logic [2:0] alu_op_q, alu_op_d;
    logic [7:0] res_buf_q [NUM_OPS];
    logic [7:0] res_buf_d [NUM_OPS];
    logic [7:0] res_data_q, res_data_d;
    logic       res_valid_q, res_valid_d;
    logic       start_ready_q, start_ready_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    assign r_next = r_q + 3'd1;

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        r_d         = r_q;
        wait_d      = wait_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        res_buf_d   = res_buf_q;
        res_data_d  = res_data_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start_valid && start_ready_q) begin
                    alu_a_d  = bus.start_a;
                    alu_b_d  = bus.start_b;
                    k_d      = 3'd0;
                    alu_op_d = 3'd0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (ALU_LATENCY == 1) begin
                    state_d = CAPTURE;
                end else begin
                    wait_d  = WAIT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                wait_d = wait_q - 2'd1;
                if (wait_q == 2'd1) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                res_buf_d[k_q] = bus.alu_result;
                if (k_q < LAST_OP) begin
                    k_d      = k_q + 3'd1;
                    alu_op_d = k_q + 3'd1;
                    state_d  = ISSUE;
                end else begin
                    // Entry 0 was captured long ago, so it can be presented right away.
                    r_d        = 3'd0;
                    res_data_d = res_buf_q[0];
                    alu_op_d   = OP_IDLE;
                    state_d    = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.res_ready) begin
                    if (r_q < LAST_OP) begin
                        r_d        = r_next;
                        res_data_d = res_buf_q[r_next];
                    end else begin
                        r_d     = 3'd0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        start_ready_d = (state_d == IDLE);
        busy_d        = (state_d != IDLE);
        res_valid_d   = (state_d == DRAIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            k_q           <= 3'd0;
            r_q           <= 3'd0;
            wait_q        <= 2'd0;
            alu_a_q       <= 4'd0;
            alu_b_q       <= 4'd0;
            alu_op_q      <= OP_IDLE;
            res_data_q    <= 8'd0;
            res_valid_q   <= 1'b0;
            start_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            for (int i = 0; i < NUM_OPS; i++) begin
                res_buf_q[i] <= 8'd0;
            end
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            r_q           <= r_d;
            wait_q        <= wait_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_op_q      <= alu_op_d;
            res_data_q    <= res_data_d;
            res_valid_q   <= res_valid_d;
            start_ready_q <= start_ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            res_buf_q     <= res_buf_d;
        end
    end

    assign bus.start_ready = start_ready_q;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_op      = alu_op_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_data    = res_data_q;
    assign bus.res_op      = r_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_alu_sweep_driver.sv
// Directed bench for alu_sweep_driver: one instance with a 1-cycle ALU model and
// one with a 3-stage ALU model, selected by use_l3 for stimulus and observation.
module tb_alu_sweep_driver;

    logic       clk;
    logic       rst;
    logic       use_l3;
    logic       start_valid;
    logic [3:0] start_a;
    logic [3:0] start_b;
    logic       res_ready;
    logic       busy1, done1, busy3, done3;

    int vectors     = 0;
    int miscompares = 0;
    int done_count  = 0;

    logic [7:0] got_data [6];
    logic [2:0] got_op   [6];
    int         got_n;
    int         unstable;

    logic [7:0] res1;
    logic [7:0] pipe3 [3];

    alu_sweep_driver_if bus1 ();
    alu_sweep_driver_if bus3 ();

    alu_sweep_driver #(.ALU_LATENCY(1), .NUM_OPS(6)) dut1 (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus1),
        .busy (busy1),
        .done (done1)
    );

    alu_sweep_driver #(.ALU_LATENCY(3), .NUM_OPS(6)) dut3 (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus3),
        .busy (busy3),
        .done (done3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus1.start_valid = start_valid && !use_l3;
    assign bus3.start_valid = start_valid && use_l3;
    assign bus1.start_a     = start_a;
    assign bus1.start_b     = start_b;
    assign bus3.start_a     = start_a;
    assign bus3.start_b     = start_b;
    assign bus1.res_ready   = res_ready;
    assign bus3.res_ready   = res_ready;

    // Reference ALU: add, sub, mul, div (0xFF on b=0), and, or; other opcodes give 0.
    function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] op);
        logic [7:0] wa;
        logic [7:0] wb;
        wa = {4'd0, a};
        wb = {4'd0, b};
        case (op)
            3'd0:    return wa + wb;
            3'd1:    return wa - wb;
            3'd2:    return wa * wb;
            3'd3:    return (b == 4'd0) ? 8'hFF : wa / wb;
            3'd4:    return wa & wb;
            3'd5:    return wa | wb;
            default: return 8'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        res1     <= alu_f(bus1.alu_a, bus1.alu_b, bus1.alu_op);
        pipe3[0] <= alu_f(bus3.alu_a, bus3.alu_b, bus3.alu_op);
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end

    assign bus1.alu_result = res1;
    assign bus3.alu_result = pipe3[2];

    logic       obs_start_ready, obs_busy, obs_done, obs_res_valid;
    logic [7:0] obs_res_data;
    logic [2:0] obs_res_op, obs_alu_op;
    logic [3:0] obs_alu_a, obs_alu_b;

    assign obs_start_ready = use_l3 ? bus3.start_ready : bus1.start_ready;
    assign obs_busy        = use_l3 ? busy3 : busy1;
    assign obs_done        = use_l3 ? done3 : done1;
    assign obs_res_valid   = use_l3 ? bus3.res_valid : bus1.res_valid;
    assign obs_res_data    = use_l3 ? bus3.res_data : bus1.res_data;
    assign obs_res_op      = use_l3 ? bus3.res_op : bus1.res_op;
    assign obs_alu_op      = use_l3 ? bus3.alu_op : bus1.alu_op;
    assign obs_alu_a       = use_l3 ? bus3.alu_a : bus1.alu_a;
    assign obs_alu_b       = use_l3 ? bus3.alu_b : bus1.alu_b;

    always @(posedge clk) begin
        if (obs_done === 1'b1) done_count <= done_count + 1;
    end

    task automatic start_sweep(input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        start_a     = a;
        start_b     = b;
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
    endtask

    task automatic wait_results(output int cycles);
        cycles = 0;
        while (obs_res_valid !== 1'b1 && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    // Collects up to six transfers; stall=1 applies ready 1,0,0,1,0,0,...
    task automatic drain_results(input bit stall, input bit poke);
        int         cyc;
        bit         have_prev;
        logic [7:0] prev_d;
        logic [2:0] prev_o;
        logic       rdy;
        cyc       = 0;
        have_prev = 0;
        got_n     = 0;
        unstable  = 0;
        prev_d    = 8'd0;
        prev_o    = 3'd0;
        for (int i = 0; i < 6; i++) begin
            got_data[i] = 8'hA5;
            got_op[i]   = 3'd7;
        end
        while (got_n < 6 && cyc < 100) begin
            rdy       = stall ? (cyc % 3 == 0) : 1'b1;
            res_ready = rdy;
            if (poke) start_valid = (cyc == 1);
            if (obs_res_valid === 1'b1) begin
                if (have_prev && (obs_res_data !== prev_d || obs_res_op !== prev_o)) unstable++;
                if (rdy) begin
                    got_data[got_n] = obs_res_data;
                    got_op[got_n]   = obs_res_op;
                    got_n++;
                    have_prev = 0;
                end else begin
                    prev_d    = obs_res_data;
                    prev_o    = obs_res_op;
                    have_prev = 1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        if (poke) start_valid = 1'b0;
        res_ready = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (obs_start_ready !== 1'b1 || obs_busy !== 1'b0 || obs_done !== 1'b0 || obs_res_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl: got ready=%b busy=%b done=%b valid=%b, expected 1 0 0 0",
                     obs_start_ready, obs_busy, obs_done, obs_res_valid);
        end
        vectors++;
        if (obs_alu_op !== 3'b111 || obs_alu_a !== 4'd0 || obs_alu_b !== 4'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_alu: got op=%0d a=%0d b=%0d, expected 7 0 0", obs_alu_op, obs_alu_a, obs_alu_b);
        end
        vectors++;
        if (obs_res_data !== 8'd0 || obs_res_op !== 3'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_res: got data=0x%02h op=%0d, expected 0x00 0", obs_res_data, obs_res_op);
        end
    endtask

    task automatic test_basic_sweep();
        logic [7:0] exp_d [6] = '{8'd12, 8'd6, 8'd27, 8'd3, 8'd1, 8'd11};
        int cycles;
        int d0;
        use_l3 = 1'b0;
        d0 = done_count;
        start_sweep(4'd9, 4'd3);
        vectors++;
        if (obs_busy !== 1'b1 || obs_start_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL basic_busy: got busy=%b ready=%b, expected 1 0", obs_busy, obs_start_ready);
        end
        wait_results(cycles);
        vectors++;
        if (cycles != 12) begin
            miscompares++;
            $display("[TB] FAIL basic_latency: got %0d cycles, expected 12", cycles);
        end
        drain_results(1'b0, 1'b0);
        vectors++;
        if (got_n != 6) begin
            miscompares++;
            $display("[TB] FAIL basic_count: got %0d transfers, expected 6", got_n);
        end
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (got_data[i] !== exp_d[i] || got_op[i] !== 3'(i)) begin
                miscompares++;
                $display("[TB] FAIL basic_result[%0d]: got data=0x%02h op=%0d, expected 0x%02h %0d",
                         i, got_data[i], got_op[i], exp_d[i], i);
            end
        end
        vectors++;
        if (obs_done !== 1'b1 || obs_start_ready !== 1'b1 || obs_busy !== 1'b0 || obs_res_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL basic_done: got done=%b ready=%b busy=%b valid=%b, expected 1 1 0 0",
                     obs_done, obs_start_ready, obs_busy, obs_res_valid);
        end
        @(negedge clk);
        vectors++;
        if (obs_done !== 1'b0 || done_count - d0 != 1 || obs_alu_op !== 3'b111 || obs_alu_a !== 4'd9) begin
            miscompares++;
            $display("[TB] FAIL basic_after: got done=%b pulses=%0d op=%0d a=%0d, expected 0 1 7 9",
                     obs_done, done_count - d0, obs_alu_op, obs_alu_a);
        end
    endtask

    task automatic test_wrap_div();
        logic [7:0] exp_w [6] = '{8'd8, 8'hFE, 8'd15, 8'd0, 8'd1, 8'd7};
        logic [7:0] exp_z [6] = '{8'd7, 8'd7, 8'd0, 8'hFF, 8'd0, 8'd7};
        int cycles;
        use_l3 = 1'b0;
        start_sweep(4'd3, 4'd5);
        wait_results(cycles);
        drain_results(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (got_data[i] !== exp_w[i] || got_op[i] !== 3'(i)) begin
                miscompares++;
                $display("[TB] FAIL wrap_result[%0d]: got data=0x%02h op=%0d, expected 0x%02h %0d",
                         i, got_data[i], got_op[i], exp_w[i], i);
            end
        end
        start_sweep(4'd7, 4'd0);
        wait_results(cycles);
        drain_results(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (got_data[i] !== exp_z[i] || got_op[i] !== 3'(i)) begin
                miscompares++;
                $display("[TB] FAIL divzero_result[%0d]: got data=0x%02h op=%0d, expected 0x%02h %0d",
                         i, got_data[i], got_op[i], exp_z[i], i);
            end
        end
    endtask

    task automatic test_latency();
        logic [7:0] exp_d [6] = '{8'd30, 8'd0, 8'd225, 8'd1, 8'd15, 8'd15};
        int cycles;
        use_l3 = 1'b1;
        start_sweep(4'd15, 4'd15);
        wait_results(cycles);
        vectors++;
        if (cycles != 24) begin
            miscompares++;
            $display("[TB] FAIL lat3_latency: got %0d cycles, expected 24", cycles);
        end
        drain_results(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (got_data[i] !== exp_d[i] || got_op[i] !== 3'(i)) begin
                miscompares++;
                $display("[TB] FAIL lat3_result[%0d]: got data=0x%02h op=%0d, expected 0x%02h %0d",
                         i, got_data[i], got_op[i], exp_d[i], i);
            end
        end
        vectors++;
        if (obs_done !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL lat3_done: got done=%b, expected 1", obs_done);
        end
        use_l3 = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_d [6] = '{8'd8, 8'd4, 8'd12, 8'd3, 8'd2, 8'd6};
        int cycles;
        use_l3 = 1'b0;
        start_sweep(4'd6, 4'd2);
        wait_results(cycles);
        drain_results(1'b1, 1'b1);
        vectors++;
        if (got_n != 6 || unstable != 0) begin
            miscompares++;
            $display("[TB] FAIL bp_stream: got transfers=%0d unstable=%0d, expected 6 0", got_n, unstable);
        end
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (got_data[i] !== exp_d[i] || got_op[i] !== 3'(i)) begin
                miscompares++;
                $display("[TB] FAIL bp_result[%0d]: got data=0x%02h op=%0d, expected 0x%02h %0d",
                         i, got_data[i], got_op[i], exp_d[i], i);
            end
        end
        vectors++;
        if (obs_done !== 1'b1 || obs_busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_done: got done=%b busy=%b, expected 1 0", obs_done, obs_busy);
        end
        @(negedge clk);
        vectors++;
        if (obs_busy !== 1'b0 || obs_start_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL bp_ignored_start: got busy=%b ready=%b, expected 0 1", obs_busy, obs_start_ready);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [7:0] exp_d [6] = '{8'd2, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1};
        int cycles;
        int d0;
        use_l3 = 1'b1;
        start_sweep(4'd5, 4'd2);
        repeat (9) @(negedge clk);
        vectors++;
        if (obs_alu_op !== 3'd2 || obs_busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL mid_pre: got op=%0d busy=%b, expected 2 1", obs_alu_op, obs_busy);
        end
        d0 = done_count;
        rst = 1'b1;
        #1;
        vectors++;
        if (obs_alu_op !== 3'b111 || obs_res_valid !== 1'b0 || obs_busy !== 1'b0 || obs_start_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL mid_reset: got op=%0d valid=%b busy=%b ready=%b, expected 7 0 0 1",
                     obs_alu_op, obs_res_valid, obs_busy, obs_start_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        vectors++;
        if (done_count != d0 || obs_busy !== 1'b0 || obs_res_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL mid_quiet: got pulses=%0d busy=%b valid=%b, expected 0 0 0",
                     done_count - d0, obs_busy, obs_res_valid);
        end
        start_sweep(4'd1, 4'd1);
        wait_results(cycles);
        drain_results(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (got_data[i] !== exp_d[i] || got_op[i] !== 3'(i)) begin
                miscompares++;
                $display("[TB] FAIL mid_fresh[%0d]: got data=0x%02h op=%0d, expected 0x%02h %0d",
                         i, got_data[i], got_op[i], exp_d[i], i);
            end
        end
        @(negedge clk);
        vectors++;
        if (done_count - d0 != 1) begin
            miscompares++;
            $display("[TB] FAIL mid_pulses: got %0d done pulses, expected 1", done_count - d0);
        end
        use_l3 = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_1 [6] = '{8'd3, 8'd1, 8'd2, 8'd2, 8'd0, 8'd3};
        logic [7:0] exp_2 [6] = '{8'd8, 8'd0, 8'd16, 8'd1, 8'd4, 8'd4};
        int cycles;
        use_l3 = 1'b0;
        @(negedge clk);
        start_a     = 4'd2;
        start_b     = 4'd1;
        start_valid = 1'b1;
        @(negedge clk);
        // Operands change while the first sweep runs and must not be re-sampled.
        start_a = 4'd4;
        start_b = 4'd4;
        wait_results(cycles);
        drain_results(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (got_data[i] !== exp_1[i] || got_op[i] !== 3'(i)) begin
                miscompares++;
                $display("[TB] FAIL b2b_first[%0d]: got data=0x%02h op=%0d, expected 0x%02h %0d",
                         i, got_data[i], got_op[i], exp_1[i], i);
            end
        end
        vectors++;
        if (obs_done !== 1'b1 || obs_start_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL b2b_done: got done=%b ready=%b, expected 1 1", obs_done, obs_start_ready);
        end
        @(negedge clk);
        start_valid = 1'b0;
        vectors++;
        if (obs_busy !== 1'b1 || obs_done !== 1'b0 || obs_alu_a !== 4'd4) begin
            miscompares++;
            $display("[TB] FAIL b2b_accept: got busy=%b done=%b a=%0d, expected 1 0 4", obs_busy, obs_done, obs_alu_a);
        end
        wait_results(cycles);
        vectors++;
        if (cycles != 12) begin
            miscompares++;
            $display("[TB] FAIL b2b_latency: got %0d cycles, expected 12", cycles);
        end
        drain_results(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (got_data[i] !== exp_2[i] || got_op[i] !== 3'(i)) begin
                miscompares++;
                $display("[TB] FAIL b2b_second[%0d]: got data=0x%02h op=%0d, expected 0x%02h %0d",
                         i, got_data[i], got_op[i], exp_2[i], i);
            end
        end
    endtask

    initial begin
        rst         = 1'b1;
        use_l3      = 1'b0;
        start_valid = 1'b0;
        start_a     = 4'd0;
        start_b     = 4'd0;
        res_ready   = 1'b1;
        res1        = 8'd0;
        for (int i = 0; i < 3; i++) pipe3[i] = 8'd0;
        $display("[TB] starting alu_sweep_driver bench");
        test_reset();
        test_basic_sweep();
        test_wrap_div();
        test_latency();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
